// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry registered skid stage with flush and stall counter
// All outputs come straight from registers; in_ready has no path from out_ready or in_valid.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid, main_valid_n;
  logic [DATA_W-1:0] main_data, main_data_n;
  logic              skid_valid, skid_valid_n;
  logic [DATA_W-1:0] skid_data, skid_data_n;
  logic [1:0]        occupancy_n;
  logic [CNT_W-1:0]  stall_cnt_n;
  logic              in_fire, out_fire, stall;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;
  assign stall    = main_valid & ~out_ready;

  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;

    if (flush) begin
      main_valid_n = 1'b0;
      main_data_n  = '0;
      skid_valid_n = 1'b0;
      skid_data_n  = '0;
    end else if (!main_valid || out_fire) begin
      // skid drains first; in_fire cannot coincide since in_ready is low while skid holds
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else if (in_fire) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end

    occupancy_n = {1'b0, main_valid_n} + {1'b0, skid_valid_n};
  end

  always_comb begin
    stall_cnt_n = stall_cnt;
    if (cnt_clr) begin
      stall_cnt_n = '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt_n = stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      occupancy  <= 2'd0;
      stall_cnt  <= '0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      occupancy  <= occupancy_n;
      stall_cnt  <= stall_cnt_n;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed and random self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    occupancy;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_d;
  logic          rdy_a, rdy_b;

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    tick();
    reset = 1'b0;

    // pass-through
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 8'hA1; tick();
    chk("pt_a1", 32'(out_data), 32'hA1); chk("pt_v1", 32'(out_valid), 1);
    chk("pt_rdy1", 32'(in_ready), 1); chk("pt_occ1", 32'(occupancy), 1);
    in_data = 8'hA2; tick();
    chk("pt_a2", 32'(out_data), 32'hA2); chk("pt_rdy2", 32'(in_ready), 1);
    in_data = 8'hA3; tick();
    chk("pt_a3", 32'(out_data), 32'hA3); chk("pt_occ3", 32'(occupancy), 1);
    in_valid = 1'b0; tick();
    chk("pt_empty", 32'(out_valid), 0); chk("pt_occ0", 32'(occupancy), 0);
    chk("pt_stall", 32'(stall_cnt), 0);

    // back-pressure fill
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hB1; tick();
    chk("bp_b1", 32'(out_data), 32'hB1); chk("bp_rdy1", 32'(in_ready), 1);
    in_data = 8'hB2; tick();
    chk("bp_rdy2", 32'(in_ready), 0); chk("bp_occ2", 32'(occupancy), 2);
    chk("bp_hold1", 32'(out_data), 32'hB1);
    in_data = 8'hB3; tick();
    chk("bp_rdy3", 32'(in_ready), 0); chk("bp_occ3", 32'(occupancy), 2);
    chk("bp_hold2", 32'(out_data), 32'hB1); chk("bp_stall", 32'(stall_cnt), 2);
    out_ready = 1'b1; tick();
    chk("bp_d2", 32'(out_data), 32'hB2); chk("bp_rdy_move", 32'(in_ready), 1);
    chk("bp_occ_move", 32'(occupancy), 1);
    tick();
    chk("bp_d3", 32'(out_data), 32'hB3); chk("bp_v3", 32'(out_valid), 1);
    in_valid = 1'b0; tick();
    chk("bp_empty", 32'(out_valid), 0); chk("bp_stall_keep", 32'(stall_cnt), 2);

    // flush with full stage
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hE1; tick();
    in_data = 8'hE2; tick();
    chk("fl_occ2", 32'(occupancy), 2);
    flush = 1'b1; in_data = 8'hC1; tick();
    chk("fl_v", 32'(out_valid), 0); chk("fl_occ", 32'(occupancy), 0);
    chk("fl_rdy", 32'(in_ready), 1); chk("fl_data", 32'(out_data), 0);
    chk("fl_stall", 32'(stall_cnt), 4);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("fl_no_c1", 32'(out_valid), 0);

    // counter saturation
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hF1; tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_15", 32'(stall_cnt), 15);
    tick();
    chk("sat_hold", 32'(stall_cnt), 15); chk("sat_data", 32'(out_data), 32'hF1);
    cnt_clr = 1'b1; tick();
    chk("clr_0", 32'(stall_cnt), 0);
    cnt_clr = 1'b0; tick();
    chk("clr_inc", 32'(stall_cnt), 1);
    cnt_clr = 1'b1; tick();
    chk("clr_prio", 32'(stall_cnt), 0);
    cnt_clr = 1'b0;

    // async reset mid-operation
    in_valid = 1'b1; in_data = 8'hF2; tick();
    chk("ar_occ2", 32'(occupancy), 2);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("ar_v", 32'(out_valid), 0); chk("ar_occ", 32'(occupancy), 0);
    chk("ar_rdy", 32'(in_ready), 1); chk("ar_stall", 32'(stall_cnt), 0);
    chk("ar_data", 32'(out_data), 0);
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1; tick();
    chk("ar_no_accept", 32'(out_valid), 0);
    reset = 1'b0; in_data = 8'hD1; tick();
    chk("ar_d1", 32'(out_data), 32'hD1); chk("ar_d1_v", 32'(out_valid), 1);
    in_valid = 1'b0; tick();
    chk("ar_empty", 32'(out_valid), 0);

    // random valid/ready stress with scoreboard
    for (int i = 0; i < 10000; i++) begin
      out_ready = 1'b0; #1; rdy_a = in_ready;
      out_ready = 1'b1; #1; rdy_b = in_ready;
      chk("st_rdy_indep", 32'(rdy_a), 32'(rdy_b));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("st_underflow", 32'(sb.size()), 1);
        end else begin
          exp_d = sb.pop_front();
          chk("st_data", 32'(out_data), 32'(exp_d));
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      tick();
      chk("st_occ", 32'(occupancy), 32'(sb.size()));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    while (sb.size() != 0 && out_valid) begin
      exp_d = sb.pop_front();
      chk("st_drain", 32'(out_data), 32'(exp_d));
      tick();
    end
    chk("st_left", 32'(sb.size()), 0);
    chk("st_final_v", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the payload carried through the stage.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the stall-cycle counter.
REQ-003 The block SHALL have these ports, one per line, clock and reset first:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  upstream offers a payload
- in_data  input  DATA_W  upstream payload
- in_ready  output  1  stage accepts a payload this cycle
- out_valid  output  1  stage presents a payload
- out_data  output  DATA_W  presented payload
- out_ready  input  1  downstream accepts the presented payload
- occupancy  output  2  number of held entries, 0..2
- cnt_clr  input  1  synchronous clear of stall_cnt
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles

Function
REQ-004 The block SHALL hold two entries: main (valid bit and data) and skid (valid bit and data).
REQ-005 out_valid SHALL equal main valid and out_data SHALL equal main data; both come directly from registers.
REQ-006 in_ready SHALL equal NOT skid valid, taken from a register, with no combinational path from out_ready or in_valid.
REQ-007 in_fire SHALL be in_valid AND in_ready; out_fire SHALL be out_valid AND out_ready.
REQ-008 When main is empty or out_fire is 1, main SHALL load on the next edge as follows, in priority order:
- skid if skid is valid, with skid then cleared;
- otherwise in_data if in_fire is 1;
- otherwise main becomes empty.
REQ-009 When main is valid, out_fire is 0 and in_fire is 1, skid SHALL capture in_data and become valid.
REQ-010 With skid valid and out_fire 1, skid SHALL move to main and in_ready SHALL be 1 in the following cycle; no payload SHALL be accepted in the move cycle.
REQ-011 Latency from in_fire to out_valid SHALL be 1 cycle when the stage is empty; sustained throughput SHALL be 1 payload per cycle while out_ready is held at 1.
REQ-012 While out_valid is 1 and out_ready is 0, out_data SHALL remain stable.
REQ-013 Payload order SHALL be preserved; no payload SHALL be dropped or duplicated, except by flush.
REQ-014 flush SHALL have priority over all transfers: on the next edge both valid bits and both data registers SHALL be 0.
REQ-015 Any in_fire in a flush cycle SHALL be discarded.
REQ-016 flush SHALL NOT affect stall_cnt.
REQ-017 occupancy SHALL equal main valid plus skid valid, registered, with legal values 0, 1 and 2.
REQ-018 stall_cnt SHALL increment by 1 on each edge where out_valid is 1 and out_ready is 0.
REQ-019 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 cnt_clr SHALL set stall_cnt to 0 on the next edge and SHALL take priority over an increment in the same cycle.

Reset
REQ-021 While reset is 1, regardless of clk, all of the following SHALL hold:
- main valid and skid valid = 0, and out_valid = 0;
- both data registers and out_data = 0;
- in_ready = 1;
- occupancy = 0;
- stall_cnt = 0.
REQ-022 Reset asserted mid-transfer SHALL discard held entries; the first accepted payload after reset release SHALL be the first one presented.
REQ-023 Behaviour SHALL resume on the first rising edge after reset deasserts; no payload SHALL be accepted while reset is 1.

Verification
REQ-024 Pass-through: out_ready=1; in_data 0xA1, 0xA2, 0xA3 on consecutive cycles -> out_data A1, A2, A3 one cycle later each; in_ready stays 1; occupancy <= 1; stall_cnt = 0.
REQ-025 Back-pressure fill: out_ready=0; offer 0xB1, 0xB2, 0xB3 -> B1 and B2 accepted, in_ready falls after B2 and B3 is held upstream, occupancy = 2; raise out_ready -> B1, B2, B3 delivered in order with no gap after the first.
REQ-026 Flush with full stage: occupancy = 2; assert flush with in_valid=1, in_data=0xC1 -> next cycle out_valid=0, occupancy=0, in_ready=1; C1 never appears at the output.
REQ-027 Counter saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt = 15 and stays at 15; cnt_clr pulse -> 0; cnt_clr and a stall in the same cycle -> 0.
REQ-028 Async reset mid-operation: occupancy=2, assert reset between clock edges -> out_valid=0, occupancy=0, in_ready=1 and stall_cnt=0 immediately; after release, 0xD1 offered -> out_data=0xD1 one cycle later.
REQ-029 Random valid/ready stress (10k cycles, scoreboard) -> in-order, lossless delivery; in_ready never depends combinationally on out_ready.
